// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way arbiter with a registered one-hot grant.
// A holder may keep the grant for up to MAX_HOLD consecutive cycles while it
// keeps requesting. After that it is excluded from arbitration whenever
// another requester is active. Selection is round-robin from ptr_r, or fixed
// priority (index 0 highest) when FIXED_PRI = 1. Every output is registered,
// so there is no combinational path from req to the outputs.
module rr_arbiter_n #(
   parameter int N         = 3,
   parameter int MAX_HOLD  = 1,
   parameter int FIXED_PRI = 0,
   parameter int IDW       = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   granted_req,
   output logic           grant_valid,
   output logic [IDW-1:0] granted_id
);

   localparam int HCW = $clog2(MAX_HOLD + 1);

   logic [IDW-1:0] ptr_r;
   logic [IDW-1:0] ptr_s;
   logic [HCW-1:0] hcnt_r;
   logic [HCW-1:0] hcnt_s;
   logic           holder_req_s;
   logic           others_req_s;
   logic           expired_s;
   logic           hold_s;
   logic [N-1:0]   mask_s;
   logic [IDW-1:0] base_s;
   logic           win_found_s;
   logic [IDW-1:0] win_idx_s;
   int             best_dist_s;
   logic [N-1:0]   grant_s;
   logic           valid_s;
   logic [IDW-1:0] id_s;

   // Qualify the current holder: still requesting, burst expired, competition present
   always_comb begin
      holder_req_s = |(req & granted_req);
      others_req_s = |(req & ~granted_req);
      expired_s    = (hcnt_r >= HCW'(MAX_HOLD));
      hold_s       = grant_valid & holder_req_s & ~expired_s;
      if (grant_valid && holder_req_s && expired_s && others_req_s) begin
         mask_s = req & ~granted_req;
      end else begin
         mask_s = req;
      end
   end

   // Pick the set bit of mask_s closest to base_s in upward, wrapping order
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      best_dist_s = N;
      if (FIXED_PRI != 0) begin
         base_s = '0;
      end else begin
         base_s = ptr_r;
      end
      for (int i = 0; i < N; i++) begin
         if (mask_s[i] && (((i - int'(base_s) + N) % N) < best_dist_s)) begin
            win_found_s = 1'b1;
            win_idx_s   = IDW'(i);
            best_dist_s = (i - int'(base_s) + N) % N;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next grant, hold counter and pointer: hold, new grant, or idle
   always_comb begin
      grant_s = '0;
      valid_s = 1'b0;
      id_s    = '0;
      hcnt_s  = '0;
      ptr_s   = ptr_r;
      if (hold_s) begin
         grant_s = granted_req;
         valid_s = 1'b1;
         id_s    = granted_id;
         hcnt_s  = hcnt_r + HCW'(1);
      end else if (win_found_s) begin
         for (int i = 0; i < N; i++) begin
            grant_s[i] = (win_idx_s == IDW'(i));
         end
         valid_s = 1'b1;
         id_s    = win_idx_s;
         hcnt_s  = HCW'(1);
         if (win_idx_s == IDW'(N - 1)) begin
            ptr_s = '0;
         end else begin
            ptr_s = win_idx_s + IDW'(1);
         end
      end else begin
         // Idle: outputs clear, ptr_r is kept so priority survives the gap
         grant_s = '0;
         valid_s = 1'b0;
         id_s    = '0;
         hcnt_s  = '0;
         ptr_s   = ptr_r;
      end
   end

   // State and output registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         granted_req <= '0;
         grant_valid <= 1'b0;
         granted_id  <= '0;
         ptr_r       <= '0;
         hcnt_r      <= '0;
      end else begin
         granted_req <= grant_s;
         grant_valid <= valid_s;
         granted_id  <= id_s;
         ptr_r       <= ptr_s;
         hcnt_r      <= hcnt_s;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Testbench for rr_arbiter_n. It uses four parameterisations.
// Directed vectors push hand-computed grants into a scoreboard queue, and a
// monitor pops and compares them after each rising edge. A random phase on
// the 8-way instance checks the structural properties of the grant.
module tb_rr_arbiter_n;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req3, g3;
   logic       v3;
   logic [1:0] id3;
   logic [4:0] req5, g5;
   logic       v5;
   logic [2:0] id5;
   logic [3:0] req4, g4;
   logic       v4;
   logic [1:0] id4;
   logic [7:0] req8, g8;
   logic       v8;
   logic [2:0] id8;

   int vectors     = 0;
   int miscompares = 0;
   int tag_cnt     = 0;
   logic rnd_on    = 1'b0;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
      logic [7:0] tag;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   rr_arbiter_n #(.N(3)) u3 (
      .clk(clk), .reset(reset), .req(req3),
      .granted_req(g3), .grant_valid(v3), .granted_id(id3));
   rr_arbiter_n #(.N(5), .MAX_HOLD(3)) u5 (
      .clk(clk), .reset(reset), .req(req5),
      .granted_req(g5), .grant_valid(v5), .granted_id(id5));
   rr_arbiter_n #(.N(4), .MAX_HOLD(2), .FIXED_PRI(1)) u4 (
      .clk(clk), .reset(reset), .req(req4),
      .granted_req(g4), .grant_valid(v4), .granted_id(id4));
   rr_arbiter_n #(.N(8), .MAX_HOLD(2)) u8 (
      .clk(clk), .reset(reset), .req(req8),
      .granted_req(g8), .grant_valid(v8), .granted_id(id8));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      vectors++;
      if (act !== req_v) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req_v);
      end
   endtask

   // Apply one request vector before the next edge and queue the expected grant
   task automatic drive(input logic [3:0] sel, input logic [7:0] r, input logic [7:0] g,
                        input logic [2:0] id, input logic v, input logic rst_v);
      exp_t e;
      @(negedge clk);
      reset = rst_v;
      case (sel)
         4'd3:    req3 = r[2:0];
         4'd4:    req4 = r[3:0];
         4'd5:    req5 = r[4:0];
         default: req8 = r;
      endcase
      e.sel = sel;
      e.g   = g;
      e.id  = id;
      e.v   = v;
      e.tag = 8'(tag_cnt);
      tag_cnt++;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t       e;
      logic [7:0] ag;
      logic [2:0] ai;
      logic       av;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
               4'd3:    begin ag = {5'd0, g3}; ai = {1'b0, id3}; av = v3; end
               4'd4:    begin ag = {4'd0, g4}; ai = {1'b0, id4}; av = v4; end
               4'd5:    begin ag = {3'd0, g5}; ai = id5;         av = v5; end
               default: begin ag = g8;         ai = id8;         av = v8; end
            endcase
            chk($sformatf("grant#%0d(n%0d)", e.tag, e.sel), 32'(ag), 32'(e.g));
            chk($sformatf("id#%0d(n%0d)", e.tag, e.sel), 32'(ai), 32'(e.id));
            chk($sformatf("valid#%0d(n%0d)", e.tag, e.sel), 32'(av), 32'(e.v));
         end
      end
   end

   // Property checker for the random phase on the 8-way instance
   initial begin
      int wait_c[8];
      int exp_id;
      int worst;
      int bound;
      bound = 7 * 2 + 1;
      for (int i = 0; i < 8; i++) wait_c[i] = 0;
      forever begin
         @(posedge clk);
         #2;
         if (rnd_on) begin
            exp_id = 0;
            worst  = 0;
            for (int i = 0; i < 8; i++) begin
               if (g8[i]) exp_id = i;
               if (req8[i] && !g8[i]) wait_c[i] = wait_c[i] + 1;
               else wait_c[i] = 0;
               if (wait_c[i] > worst) worst = wait_c[i];
            end
            chk("rnd_onehot", 32'(g8 & (g8 - 8'd1)), 32'd0);
            chk("rnd_subset", 32'(g8 & ~req8), 32'd0);
            chk("rnd_id", 32'(id8), 32'(exp_id));
            chk("rnd_valid", 32'(v8), 32'(g8 != 8'd0));
            chk("rnd_starve", 32'(worst > bound), 32'd0);
         end else begin
            for (int i = 0; i < 8; i++) wait_c[i] = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   // Directed stimulus
   initial begin
      reset = 1'b0;
      req3 = 3'd0; req4 = 4'd0; req5 = 5'd0; req8 = 8'd0;
      #2;
      chk("rst_g3", 32'(g3), 32'd0);
      chk("rst_v3", 32'(v3), 32'd0);
      chk("rst_id3", 32'(id3), 32'd0);
      chk("rst_g8", 32'(g8), 32'd0);
      chk("rst_v5", 32'(v5), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 3-way round-robin basics
      drive(4'd3, 8'b001, 8'b001, 3'd0, 1'b1, 1'b1);
      drive(4'd3, 8'b010, 8'b010, 3'd1, 1'b1, 1'b1);
      drive(4'd3, 8'b100, 8'b100, 3'd2, 1'b1, 1'b1);
      drive(4'd3, 8'b000, 8'b000, 3'd0, 1'b0, 1'b1);
      drive(4'd3, 8'b111, 8'b001, 3'd0, 1'b1, 1'b1);
      drive(4'd3, 8'b111, 8'b010, 3'd1, 1'b1, 1'b1);
      drive(4'd3, 8'b111, 8'b100, 3'd2, 1'b1, 1'b1);
      drive(4'd3, 8'b111, 8'b001, 3'd0, 1'b1, 1'b1);
      drive(4'd3, 8'b000, 8'b000, 3'd0, 1'b0, 1'b1);
      drive(4'd3, 8'b110, 8'b010, 3'd1, 1'b1, 1'b1);
      drive(4'd3, 8'b110, 8'b100, 3'd2, 1'b1, 1'b1);
      drive(4'd3, 8'b000, 8'b000, 3'd0, 1'b0, 1'b1);

      // 5-way, burst of 3, holder release without a dead cycle
      for (int c = 0; c < 11; c++) begin
         if ((c / 3) % 2 == 0) drive(4'd5, 8'b00011, 8'b00001, 3'd0, 1'b1, 1'b1);
         else drive(4'd5, 8'b00011, 8'b00010, 3'd1, 1'b1, 1'b1);
      end
      drive(4'd5, 8'b00001, 8'b00001, 3'd0, 1'b1, 1'b1);
      drive(4'd5, 8'b00000, 8'b00000, 3'd0, 1'b0, 1'b1);

      // 4-way fixed priority, burst of 2, expiry rotation, then sole requester
      for (int c = 0; c < 6; c++) begin
         if (c == 2 || c == 3) drive(4'd4, 8'b1110, 8'b0100, 3'd2, 1'b1, 1'b1);
         else drive(4'd4, 8'b1110, 8'b0010, 3'd1, 1'b1, 1'b1);
      end
      for (int c = 0; c < 5; c++) drive(4'd4, 8'b0010, 8'b0010, 3'd1, 1'b1, 1'b1);
      drive(4'd4, 8'b0000, 8'b0000, 3'd0, 1'b0, 1'b1);

      // 8-way random traffic
      rnd_on = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         for (int b = 0; b < 8; b++) req8[b] = ($urandom_range(3, 0) != 0);
         if (c % 97 == 0) req8 = 8'h00;
      end
      @(negedge clk);
      req8 = 8'h00;
      @(posedge clk);
      #3;
      rnd_on = 1'b0;

      // Asynchronous reset mid-burst on the 3-way instance
      drive(4'd3, 8'b111, 8'b001, 3'd0, 1'b1, 1'b1);
      drive(4'd3, 8'b111, 8'b010, 3'd1, 1'b1, 1'b1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_g3", 32'(g3), 32'd0);
      chk("async_v3", 32'(v3), 32'd0);
      chk("async_id3", 32'(id3), 32'd0);
      drive(4'd3, 8'b111, 8'b000, 3'd0, 1'b0, 1'b0);
      drive(4'd3, 8'b111, 8'b001, 3'd0, 1'b1, 1'b1);
      drive(4'd3, 8'b111, 8'b010, 3'd1, 1'b1, 1'b1);
      drive(4'd3, 8'b000, 8'b000, 3'd0, 1'b0, 1'b1);

      @(posedge clk);
      @(posedge clk);
      #3;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
